sd_cmd_sched: RTL and testbench

- Parametrised command scheduler between NUM_CH command sources (driver CMD, auto CMD12, auto CMD23, ...) and the single SD CMD-line engine (cmd_logic).
- Queues one command per channel and arbitrates between them.
- Routes the engine's response and error results back to the issuing channel.
- Flushes pending commands on error and reports which channels were aborted.

---
 rtl/sd_cmd_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_sd_cmd_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sched.sv
// sd_cmd_sched: command scheduler between NUM_CH command sources and the single
// SD CMD-line engine. Each channel holds one queued command. The scheduler
// arbitrates between them, issues the winner to the engine, routes the result
// back to the owning channel and, on error, flushes the other pending channels.
//
// Build option: define SD_CMD_SCHED_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest channel index wins.
//
// Handshakes (req_* and eng_*) use valid/ready semantics. A transfer happens
// on a clock edge where valid and ready are both high. Once valid is raised,
// the payload stays stable until that transfer. Ready may depend on state but
// never on valid.
//
// The state_o debug output exposes the FSM state:
// 0 = IDLE, 1 = ISSUE, 2 = WAIT, 3 = DONE.
module sd_cmd_sched #(
  parameter int                 NUM_CH     = 2,
  parameter int                 ARG_W      = 32,
  parameter int                 RSP_W      = 120,
  parameter logic [NUM_CH-1:0]  FLUSH_MASK = {NUM_CH{1'b1}},
  localparam int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sw_rst_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  input  logic [NUM_CH*6-1:0]     req_cmd_i,
  input  logic [NUM_CH*ARG_W-1:0] req_arg_i,
  input  logic [NUM_CH*2-1:0]     req_rsp_type_i,
  output logic                    eng_valid_o,
  input  logic                    eng_ready_i,
  output logic [5:0]              eng_cmd_o,
  output logic [ARG_W-1:0]        eng_arg_o,
  output logic [1:0]              eng_rsp_type_o,
  input  logic                    eng_result_valid_i,
  input  logic [RSP_W-1:0]        eng_rsp_i,
  input  logic [2:0]              eng_err_i,
  input  logic                    eng_timeout_i,
  output logic [NUM_CH-1:0]       done_o,
  output logic [3:0]              err_o,
  output logic [RSP_W-1:0]        rsp_o,
  output logic [NUM_CH-1:0]       aborted_o,
  output logic [NUM_CH-1:0]       inhibit_o,
  output logic [CH_W-1:0]         active_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   accept;
  logic [NUM_CH-1:0]   grant_oh;
  logic [NUM_CH-1:0]   flush;
  logic [CH_W-1:0]     grant_q;
  logic [CH_W-1:0]     arb_idx;
  logic [CH_W-1:0]     arb_base;
  logic                arb_found;
  logic                issue_hs;
  logic                result_in;
  logic [5:0]          slot_cmd  [NUM_CH];
  logic [ARG_W-1:0]    slot_arg  [NUM_CH];
  logic [1:0]          slot_type [NUM_CH];
  logic [RSP_W-1:0]    rsp_q;
  logic [3:0]          err_q;

  // Acceptance is blocked for occupied slots and for the whole DONE cycle,
  // so a flush can never race with a new request.
  assign req_ready_o = ~pending_q & {NUM_CH{state_q != S_DONE}};
  assign accept      = req_valid_i & req_ready_o;
  assign issue_hs    = (state_q == S_ISSUE) && eng_ready_i;
  assign result_in   = eng_result_valid_i || eng_timeout_i;

`ifdef SD_CMD_SCHED_RR_EN
  logic [CH_W-1:0] rr_ptr_q;

  // Round-robin pointer: the search starts one past the last issued channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (sw_rst_i) begin
      rr_ptr_q <= '0;
    end else if (issue_hs) begin
      rr_ptr_q <= (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + CH_W'(1);
    end
  end

  assign arb_base = rr_ptr_q;
`else
  assign arb_base = '0;
`endif

  // Arbiter: first pending channel, scanning upward from arb_base with wrap.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(arb_base) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!arb_found && pending_q[idx]) begin
        arb_found = 1'b1;
        arb_idx   = CH_W'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else if (sw_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_found) state_d = S_ISSUE;
      S_ISSUE: if (eng_ready_i) state_d = S_WAIT;
      S_WAIT:  if (result_in) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: engine request, completion and abort pulses, status.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
    flush             = '0;
    eng_valid_o       = 1'b0;
    eng_cmd_o         = '0;
    eng_arg_o         = '0;
    eng_rsp_type_o    = '0;
    done_o            = '0;
    active_o          = '0;
    if (state_q == S_ISSUE) begin
      eng_valid_o    = 1'b1;
      eng_cmd_o      = slot_cmd[grant_q];
      eng_arg_o      = slot_arg[grant_q];
      eng_rsp_type_o = slot_type[grant_q];
    end
    if (state_q == S_DONE) begin
      done_o = grant_oh;
      if ((|err_q) && FLUSH_MASK[grant_q]) flush = pending_q & ~grant_oh;
    end
    if (state_q != S_IDLE) active_o = grant_q;
  end

  assign aborted_o = flush;
  assign inhibit_o = pending_q;
  assign err_o     = err_q;
  assign rsp_o     = rsp_q;
  assign state_o   = state_q;

  // Pending set: newly accepted slots; the DONE cycle retires the grant and any flushed channels.
  always_comb begin
    pending_d = pending_q | accept;
    if (state_q == S_DONE) pending_d = pending_d & ~grant_oh & ~flush;
  end

  // Pending register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else if (sw_rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Grant is latched once in IDLE and held until the command retires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
    end else if (sw_rst_i) begin
      grant_q <= '0;
    end else if (state_q == S_IDLE && arb_found) begin
      grant_q <= arb_idx;
    end
  end

  // Per-channel command slots, written only while the slot is free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        slot_cmd[c]  <= '0;
        slot_arg[c]  <= '0;
        slot_type[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          slot_cmd[c]  <= req_cmd_i[c*6 +: 6];
          slot_arg[c]  <= req_arg_i[c*ARG_W +: ARG_W];
          slot_type[c] <= req_rsp_type_i[c*2 +: 2];
        end
      end
    end
  end

  // Result capture in WAIT; a timeout overrides all other error bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
      err_q <= '0;
    end else if (sw_rst_i) begin
      rsp_q <= '0;
      err_q <= '0;
    end else if (state_q == S_WAIT && result_in) begin
      rsp_q <= eng_rsp_i;
      err_q <= eng_timeout_i ? 4'b1000 : {1'b0, eng_err_i};
    end
  end

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Directed bench for sd_cmd_sched with three channels and the default
// fixed-priority arbitration.
module tb_sd_cmd_sched;

  localparam int NUM_CH = 3;
  localparam int ARG_W  = 32;
  localparam int RSP_W  = 120;
  localparam int CH_W   = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    sw_rst;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH*6-1:0]     req_cmd;
  logic [NUM_CH*ARG_W-1:0] req_arg;
  logic [NUM_CH*2-1:0]     req_rsp_type;
  logic                    eng_valid;
  logic                    eng_ready;
  logic [5:0]              eng_cmd;
  logic [ARG_W-1:0]        eng_arg;
  logic [1:0]              eng_rsp_type;
  logic                    eng_result_valid;
  logic [RSP_W-1:0]        eng_rsp;
  logic [2:0]              eng_err;
  logic                    eng_timeout;
  logic [NUM_CH-1:0]       done;
  logic [3:0]              err;
  logic [RSP_W-1:0]        rsp;
  logic [NUM_CH-1:0]       aborted;
  logic [NUM_CH-1:0]       inhibit;
  logic [CH_W-1:0]         active;
  logic [1:0]              state;

  int checks   = 0;
  int failures = 0;
  logic [RSP_W-1:0] exp_q[$];

  sd_cmd_sched #(
    .NUM_CH(NUM_CH),
    .ARG_W (ARG_W),
    .RSP_W (RSP_W)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .sw_rst_i          (sw_rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_cmd_i         (req_cmd),
    .req_arg_i         (req_arg),
    .req_rsp_type_i    (req_rsp_type),
    .eng_valid_o       (eng_valid),
    .eng_ready_i       (eng_ready),
    .eng_cmd_o         (eng_cmd),
    .eng_arg_o         (eng_arg),
    .eng_rsp_type_o    (eng_rsp_type),
    .eng_result_valid_i(eng_result_valid),
    .eng_rsp_i         (eng_rsp),
    .eng_err_i         (eng_err),
    .eng_timeout_i     (eng_timeout),
    .done_o            (done),
    .err_o             (err),
    .rsp_o             (rsp),
    .aborted_o         (aborted),
    .inhibit_o         (inhibit),
    .active_o          (active),
    .state_o           (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input int c, input logic [5:0] cmd, input logic [31:0] arg,
                         input logic [1:0] typ);
    req_valid[c]          = 1'b1;
    req_cmd[c*6 +: 6]     = cmd;
    req_arg[c*ARG_W +: ARG_W] = arg;
    req_rsp_type[c*2 +: 2] = typ;
  endtask

  // Pulse a result during WAIT; returns positioned in DONE.
  task automatic send_result(input logic [RSP_W-1:0] r, input logic [2:0] e);
    eng_result_valid = 1'b1;
    eng_rsp          = r;
    eng_err          = e;
    exp_q.push_back(r);
    tick();
    eng_result_valid = 1'b0;
    eng_err          = '0;
  endtask

  task automatic check_rsp(input string tag);
    logic [RSP_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, rsp, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; sw_rst = 1'b0; req_valid = '0; req_cmd = '0; req_arg = '0;
    req_rsp_type = '0; eng_ready = 1'b1; eng_result_valid = 1'b0; eng_rsp = '0;
    eng_err = '0; eng_timeout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_req_ready", req_ready, 3'b111);
    check("rst_eng_valid", eng_valid, 1'b0);
    check("rst_done", done, 3'b000);
    check("rst_inhibit", inhibit, 3'b000);
    check("rst_active", active, 2'd0);
    check("rst_err", err, 4'd0);
    check("rst_rsp", rsp, '0);
    check("rst_state", state, 2'd0);
    tick();

    // Single command on channel 1
    set_req(1, 6'd17, 32'h1000, 2'b01);
    tick();
    req_valid = '0;
    check("single_n1_valid", eng_valid, 1'b0);
    check("single_n1_inhibit", inhibit, 3'b010);
    tick();
    check("single_n2_valid", eng_valid, 1'b1);
    check("single_cmd", eng_cmd, 6'd17);
    check("single_arg", eng_arg, 32'h1000);
    check("single_type", eng_rsp_type, 2'b01);
    check("single_active", active, 2'd1);
    tick();
    check("single_wait_state", state, 2'd2);
    check("single_wait_valid", eng_valid, 1'b0);
    repeat (49) tick();
    send_result(120'hABCD, 3'b000);
    check("single_done", done, 3'b010);
    check_rsp("single_rsp");
    check("single_err", err, 4'd0);
    check("single_aborted", aborted, 3'b000);
    check("single_ready_in_done", req_ready, 3'b000);
    check("single_inhibit_done", inhibit, 3'b010);
    tick();
    check("single_after_done", done, 3'b000);
    check("single_inhibit_after", inhibit, 3'b000);
    check("single_rsp_hold", rsp, 120'hABCD);

    // Priority: ch0 and ch1 together
    set_req(0, 6'd8, 32'h0000_01AA, 2'b10);
    set_req(1, 6'd55, 32'h0000_0002, 2'b01);
    tick();
    req_valid = '0;
    check("prio_pending", inhibit, 3'b011);
    tick();
    check("prio_first_cmd", eng_cmd, 6'd8);
    check("prio_first_arg", eng_arg, 32'h1AA);
    check("prio_first_active", active, 2'd0);
    tick();
    send_result(120'h11, 3'b000);
    check("prio_first_done", done, 3'b001);
    check_rsp("prio_first_rsp");
    tick();
    check("prio_gap_valid", eng_valid, 1'b0);
    tick();
    check("prio_second_valid", eng_valid, 1'b1);
    check("prio_second_cmd", eng_cmd, 6'd55);
    check("prio_second_active", active, 2'd1);
    tick();
    send_result(120'h22, 3'b000);
    check("prio_second_done", done, 3'b010);
    check_rsp("prio_second_rsp");
    tick();

    // Error flush: ch0 in flight, ch1 and ch2 pending, crc error
    set_req(0, 6'd18, 32'h10, 2'b01);
    set_req(1, 6'd12, 32'h0, 2'b11);
    set_req(2, 6'd23, 32'h8, 2'b01);
    tick();
    req_valid = '0;
    tick();
    check("flush_issue_cmd", eng_cmd, 6'd18);
    tick();
    send_result(120'h33, 3'b010);
    check("flush_done", done, 3'b001);
    check("flush_err", err, 4'b0010);
    check("flush_aborted", aborted, 3'b110);
    check_rsp("flush_rsp");
    tick();
    check("flush_inhibit", inhibit, 3'b000);
    check("flush_aborted_gone", aborted, 3'b000);
    repeat (3) tick();
    check("flush_no_issue", eng_valid, 1'b0);
    check("flush_idle", state, 2'd0);

    // Timeout: ch1 in flight with ch2 pending, error bits must be masked
    set_req(1, 6'd2, 32'h0, 2'b11);
    set_req(2, 6'd3, 32'h0, 2'b01);
    tick();
    req_valid = '0;
    tick();
    check("tmo_issue_active", active, 2'd1);
    tick();
    eng_timeout = 1'b1;
    eng_err     = 3'b111;
    tick();
    eng_timeout = 1'b0;
    eng_err     = '0;
    check("tmo_done", done, 3'b010);
    check("tmo_err", err, 4'b1000);
    check("tmo_aborted", aborted, 3'b100);
    tick();
    check("tmo_inhibit", inhibit, 3'b000);
    tick();
    check("tmo_no_issue", eng_valid, 1'b0);

    // Backpressure with changing ch0 request, plus a stray result in ISSUE
    eng_ready = 1'b0;
    set_req(0, 6'd5, 32'h55, 2'b01);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      set_req(0, 6'($urandom_range(0, 63)), $urandom, 2'b10);
      if (i == 10) eng_result_valid = 1'b1;
      #1;
      check("bp_valid", eng_valid, 1'b1);
      check("bp_cmd", eng_cmd, 6'd5);
      check("bp_arg", eng_arg, 32'h55);
      check("bp_ready0", req_ready[0], 1'b0);
      tick();
      eng_result_valid = 1'b0;
    end
    check("bp_still_issue", state, 2'd1);
    req_valid = '0;
    eng_ready = 1'b1;
    tick();
    check("bp_wait", state, 2'd2);
    send_result(120'h1234, 3'b000);
    check("bp_done", done, 3'b001);
    check_rsp("bp_rsp");
    tick();

    // Soft reset in WAIT
    set_req(0, 6'd9, 32'h77, 2'b01);
    set_req(1, 6'd13, 32'h88, 2'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("swr_in_wait", state, 2'd2);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("swr_state", state, 2'd0);
    check("swr_inhibit", inhibit, 3'b000);
    check("swr_done", done, 3'b000);
    check("swr_aborted", aborted, 3'b000);
    check("swr_ready", req_ready, 3'b111);
    check("swr_rsp", rsp, '0);
    check("swr_err", err, 4'd0);
    eng_result_valid = 1'b1;
    eng_rsp          = 120'hDEAD;
    tick();
    eng_result_valid = 1'b0;
    check("swr_late_done", done, 3'b000);
    check("swr_late_state", state, 2'd0);
    check("swr_late_rsp", rsp, '0);
    tick();
    check("swr_no_issue", eng_valid, 1'b0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
